// File: rtl/half_adder.sv
// Half adder with a combinational result, a registered copy of that result,
// and a saturating count of captured carry events.
//
// Ports:
//   clk        - rising-edge clock for all registered state
//   rst        - asynchronous, active-high reset of the registered state
//   en         - capture enable for the registered path
//   in_a, in_b - addend bits
//   sum, carry - combinational half-adder outputs (independent of clk/rst/en)
//   sum_q      - registered sum, captured when en=1
//   carry_q    - registered carry, captured when en=1
//   valid_q    - high when sum_q/carry_q were captured on the previous edge
//   carry_cnt  - saturating count of captured operations with carry=1
module half_adder #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             in_a,
  input  logic             in_b,
  output logic             sum,
  output logic             carry,
  output logic             sum_q,
  output logic             carry_q,
  output logic             valid_q,
  output logic [CNT_W-1:0] carry_cnt
);

  assign sum   = in_a ^ in_b;
  assign carry = in_a & in_b;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q     <= 1'b0;
      carry_q   <= 1'b0;
      valid_q   <= 1'b0;
      carry_cnt <= '0;
    end else begin
      valid_q <= en;
      if (en) begin
        sum_q   <= sum;
        carry_q <= carry;
        // Stop at all-ones so the count never wraps back to zero.
        if (carry && (carry_cnt != '1)) begin
          carry_cnt <= carry_cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_half_adder.sv
`timescale 1ns/1ps
module tb_half_adder;

  logic        clk = 1'b0;
  logic        clk_run = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0;
  logic        in_a = 1'b0;
  logic        in_b = 1'b0;

  logic        sum, carry, sum_q, carry_q, valid_q;
  logic [15:0] cnt;
  logic        sum2, carry2, sum_q2, carry_q2, valid_q2;
  logic [1:0]  cnt2;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  logic        cmp_on = 1'b0;

  // Reference model state: results derived from the arithmetic sum a+b.
  int unsigned m_sum_q, m_carry_q, m_valid_q;
  longint      m_cnt, m_cnt2;
  localparam longint MAX16 = (64'd1 << 16) - 1;
  localparam longint MAX2  = (64'd1 << 2) - 1;

  half_adder u_dut (
    .clk(clk), .rst(rst), .en(en), .in_a(in_a), .in_b(in_b),
    .sum(sum), .carry(carry), .sum_q(sum_q), .carry_q(carry_q),
    .valid_q(valid_q), .carry_cnt(cnt)
  );

  half_adder #(.CNT_W(2)) u_dut2 (
    .clk(clk), .rst(rst), .en(en), .in_a(in_a), .in_b(in_b),
    .sum(sum2), .carry(carry2), .sum_q(sum_q2), .carry_q(carry_q2),
    .valid_q(valid_q2), .carry_cnt(cnt2)
  );

  always begin
    #5;
    if (clk_run) clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: on each capture the operation result is a+b; bit 0 is the sum,
  // bit 1 the carry, and the carry adds to a counter clipped at its maximum.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_sum_q = 0; m_carry_q = 0; m_valid_q = 0; m_cnt = 0; m_cnt2 = 0;
    end else begin
      int unsigned total;
      total = int'(in_a) + int'(in_b);
      m_valid_q = en ? 1 : 0;
      if (en) begin
        m_sum_q   = total % 2;
        m_carry_q = total / 2;
        m_cnt  = (m_cnt  + m_carry_q > MAX16) ? MAX16 : m_cnt  + m_carry_q;
        m_cnt2 = (m_cnt2 + m_carry_q > MAX2)  ? MAX2  : m_cnt2 + m_carry_q;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_on) begin
      int unsigned total;
      total = int'(in_a) + int'(in_b);
      chk("cyc_sum",      32'(sum),      total % 2);
      chk("cyc_carry",    32'(carry),    total / 2);
      chk("cyc_sum_q",    32'(sum_q),    m_sum_q);
      chk("cyc_carry_q",  32'(carry_q),  m_carry_q);
      chk("cyc_valid_q",  32'(valid_q),  m_valid_q);
      chk("cyc_cnt",      32'(cnt),      32'(m_cnt));
      chk("cyc_sum_q2",   32'(sum_q2),   m_sum_q);
      chk("cyc_carry_q2", 32'(carry_q2), m_carry_q);
      chk("cyc_valid_q2", 32'(valid_q2), m_valid_q);
      chk("cyc_cnt2",     32'(cnt2),     32'(m_cnt2));
    end
  end

  initial begin
    logic [1:0] pat;
    int unsigned exp6 [6];
    exp6 = '{1, 2, 3, 3, 3, 3};

    // Clock idle: combinational truth table with literal expectations.
    in_a = 0; in_b = 0; #3; chk("tt00_sum", 32'(sum), 0); chk("tt00_carry", 32'(carry), 0);
    in_a = 0; in_b = 1; #3; chk("tt01_sum", 32'(sum), 1); chk("tt01_carry", 32'(carry), 0);
    in_a = 1; in_b = 0; #3; chk("tt10_sum", 32'(sum), 1); chk("tt10_carry", 32'(carry), 0);
    in_a = 1; in_b = 1; #3; chk("tt11_sum", 32'(sum), 0); chk("tt11_carry", 32'(carry), 1);

    for (int i = 0; i < 8; i++) begin
      pat = 2'($urandom_range(0, 3));
      in_a = pat[1]; in_b = pat[0];
      #3;
      chk("rnd_sum",   32'(sum),   32'(pat[1] ^ pat[0]));
      chk("rnd_carry", 32'(carry), 32'(pat[1] & pat[0]));
    end

    // Reset takes effect with the clock stopped.
    rst = 1; #1;
    chk("rst_sum_q", 32'(sum_q), 0);
    chk("rst_carry_q", 32'(carry_q), 0);
    chk("rst_valid_q", 32'(valid_q), 0);
    chk("rst_cnt", 32'(cnt), 0);
    chk("rst_cnt2", 32'(cnt2), 0);

    clk_run = 1; en = 0;
    @(posedge clk); #2;
    rst = 0; cmp_on = 1;
    en = 1; in_a = 1; in_b = 1;
    @(posedge clk); #1;
    chk("e1_sum_q", 32'(sum_q), 0);
    chk("e1_carry_q", 32'(carry_q), 1);
    chk("e1_valid_q", 32'(valid_q), 1);
    chk("e1_cnt", 32'(cnt), 1);
    repeat (4) @(posedge clk);
    #1;
    chk("e5_cnt", 32'(cnt), 5);
    en = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("hold_cnt", 32'(cnt), 5);
    chk("hold_valid_q", 32'(valid_q), 0);
    chk("hold_sum_q", 32'(sum_q), 0);
    chk("hold_carry_q", 32'(carry_q), 1);

    // Narrow counter saturation from a clean reset.
    #2; rst = 1; #2; rst = 0;
    en = 1; in_a = 1; in_b = 1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk("sat_cnt2", 32'(cnt2), exp6[i]);
    end

    // Reset between edges with a saturated narrow counter.
    #2; rst = 1; #1;
    chk("mid_cnt2", 32'(cnt2), 0);
    chk("mid_sum_q2", 32'(sum_q2), 0);
    chk("mid_carry_q2", 32'(carry_q2), 0);
    chk("mid_valid_q2", 32'(valid_q2), 0);
    in_a = 1; in_b = 0; #1;
    chk("mid_sum", 32'(sum2), 1);
    chk("mid_carry", 32'(carry2), 0);
    @(posedge clk); #2;
    rst = 0;

    // Randomized traffic with occasional asynchronous reset pulses.
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #2;
      rst  = 0;
      en   = ($urandom % 4) != 0;
      in_a = 1'($urandom);
      in_b = 1'($urandom);
      if (($urandom % 50) == 0) begin
        #2; rst = 1;
      end
    end
    @(posedge clk); #2; rst = 0;
    @(negedge clk); #1;
    cmp_on = 0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/half_adder.md
HALF_ADDER -- requirements
Module: half_adder

Interface
REQ-001 Parameter CNT_W, default 16, SHALL set the width of the carry event counter (legal range 1..32).
REQ-002 clk  input  1  SHALL be the single clock; all registered state updates on its rising edge.
REQ-003 rst  input  1  SHALL be the reset: asynchronous, active-high.
REQ-004 en  input  1  SHALL be the capture enable for the registered path.
REQ-005 in_a  input  1  SHALL be addend bit A.
REQ-006 in_b  input  1  SHALL be addend bit B.
REQ-007 sum  output  1  SHALL be the combinational sum bit.
REQ-008 carry  output  1  SHALL be the combinational carry bit.
REQ-009 sum_q  output  1  SHALL be the registered sum bit.
REQ-010 carry_q  output  1  SHALL be the registered carry bit.
REQ-011 valid_q  output  1  SHALL flag that sum_q/carry_q hold a result captured on the previous edge.
REQ-012 carry_cnt  output  CNT_W  SHALL be the count of captured operations that produced carry=1.

Function
REQ-013 sum SHALL equal in_a XOR in_b at all times; purely combinational, zero cycles of latency.
REQ-014 carry SHALL equal in_a AND in_b at all times; purely combinational, zero cycles of latency.
REQ-015 sum and carry SHALL NOT depend on clk, rst or en; they SHALL be correct with clk idle or unconnected.
REQ-016 {carry,sum} SHALL equal the 2-bit arithmetic sum in_a+in_b for all four input combinations: 00->00, 01->01, 10->01, 11->10.
REQ-017 On a rising clk edge with en=1 and rst=0: sum_q<=in_a^in_b, carry_q<=in_a&in_b, valid_q<=1.
REQ-018 On a rising clk edge with en=0 and rst=0: sum_q and carry_q SHALL hold; valid_q<=0.
REQ-019 Registered path latency SHALL be exactly one clock: sum_q/carry_q reflect the inputs sampled at the preceding edge.
REQ-020 On a rising edge with en=1 and in_a&in_b=1, carry_cnt SHALL increment by 1.
REQ-021 carry_cnt SHALL saturate at 2^CNT_W-1; further carry events SHALL leave it unchanged (no wrap).
REQ-022 carry_cnt SHALL hold on edges with en=0 or with in_a&in_b=0.
REQ-023 Input changes between clock edges SHALL affect only sum/carry, never registered outputs.

Reset
REQ-024 rst=1 SHALL immediately, without waiting for clk, force sum_q=0, carry_q=0, valid_q=0, carry_cnt=0.
REQ-025 While rst=1 registered outputs SHALL stay at reset values regardless of clk, en, in_a, in_b.
REQ-026 Reset asserted mid-operation SHALL discard any pending capture; first capture occurs on the first rising edge after rst deasserts with en=1.
REQ-027 rst SHALL NOT affect sum or carry.

Verification
REQ-028 No clock, rst unconnected; drive (a,b)=00,01,10,11, wait 3 ns each -> sum=0,1,1,0, carry=0,0,0,1.
REQ-029 Eight random (a,b) pairs, 3 ns apart, no clock -> sum==a^b and carry==a&b after each settle.
REQ-030 rst pulse, then en=1, (a,b)=11 at edge 1 -> after edge 1 sum_q=0, carry_q=1, valid_q=1, carry_cnt=1.
REQ-031 en=1, five edges with (a,b)=11, then en=0 for two edges with (a,b)=11 -> carry_cnt=5, valid_q=0, sum_q/carry_q hold 0/1.
REQ-032 CNT_W=2, en=1, (a,b)=11 for six edges -> carry_cnt reads 1,2,3,3,3,3.
REQ-033 Assert rst between edges with carry_cnt=3 -> carry_cnt, sum_q, carry_q, valid_q read 0 before the next edge; sum/carry keep following inputs.
